// File: rtl/lp_xfer_ctrl_if.sv
// lp_xfer_ctrl_if -- bus bundle between a line-printer transfer controller and
// its host/DMA/printer environment.
//
// Signals:
//   lpMODE   [1:0]   transfer mode: 0 PRINT, 1 TEST, 2 DAVFU, 3 RAM
//   lpCMDGO          one-cycle go pulse
//   lpSTOP           abort request
//   lpBCTR   [BCWID] byte count, sampled when GO is accepted
//   dmaREQ / dmaACK / dmaDATA[15:0]   DMA word fetch
//   lpDATA[7:0] / lpSTB / lpRDY       printer character output
//   lpINCBAR         one-cycle pulse: bump bus address register
//   lpDONE           one-cycle pulse: transfer ended
//   regCSRB[15:0]    status: [0] busy, [1] undefined char, [2] GO while busy,
//                    [3] stopped
//
// Handshakes: dmaREQ is held high until a cycle with dmaACK high; that cycle
// transfers dmaDATA, and dmaREQ drops on the following edge. lpSTB is a
// single-cycle strobe that is only issued once lpRDY was seen high; lpDATA is
// valid and stable in the lpSTB cycle.
interface lp_xfer_ctrl_if #(
  parameter int BCWID = 12
);
  logic [1:0]       lpMODE;
  logic             lpCMDGO;
  logic             lpSTOP;
  logic [BCWID-1:0] lpBCTR;
  logic             dmaREQ;
  logic             dmaACK;
  logic [15:0]      dmaDATA;
  logic [7:0]       lpDATA;
  logic             lpSTB;
  logic             lpRDY;
  logic             lpINCBAR;
  logic             lpDONE;
  logic [15:0]      regCSRB;

  // Host / environment side.
  modport master (
    output lpMODE, lpCMDGO, lpSTOP, lpBCTR, dmaACK, dmaDATA, lpRDY,
    input  dmaREQ, lpDATA, lpSTB, lpINCBAR, lpDONE, regCSRB
  );

  // Controller side.
  modport slave (
    input  lpMODE, lpCMDGO, lpSTOP, lpBCTR, dmaACK, dmaDATA, lpRDY,
    output dmaREQ, lpDATA, lpSTB, lpINCBAR, lpDONE, regCSRB
  );
endinterface

// File: rtl/lp_xfer_ctrl.sv
// lp_xfer_ctrl -- line-printer transfer controller. Fetches 16-bit DMA words,
// splits them into bytes (low first) and, depending on mode, prints them
// through a 10-bit translation RAM (PRINT), prints them raw (DAVFU), discards
// them (TEST), or loads the translation RAM from the word stream (RAM).
//
// Ports:
//   clk        clock, all state changes on the rising edge
//   rst        synchronous active-high reset
//   bus        lp_xfer_ctrl_if.slave bundle (mode, go, stop, count, DMA,
//              printer, status)
//   dbg_state  current FSM state encoding
module lp_xfer_ctrl #(
  parameter int BCWID = 12,
  parameter int RAMAW = 8
) (
  input  logic                clk,
  input  logic                rst,
  lp_xfer_ctrl_if.slave       bus,
  output logic [2:0]          dbg_state
);

  localparam logic [1:0] M_PRINT = 2'd0;
  localparam logic [1:0] M_TEST  = 2'd1;
  localparam logic [1:0] M_DAVFU = 2'd2;
  localparam logic [1:0] M_RAM   = 2'd3;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_LOW    = 3'd2,
    S_XLATE  = 3'd3,
    S_OUT    = 3'd4,
    S_HIGH   = 3'd5,
    S_FINISH = 3'd6
  } state_t;

  state_t           state;
  state_t           nxt_after;
  logic [1:0]       mode;
  logic [BCWID-1:0] cnt;
  logic [15:0]      word;
  logic             hi;          // byte just handled was the high byte
  logic [RAMAW-1:0] widx;
  logic [9:0]       ram [0:(1<<RAMAW)-1];
  logic [9:0]       ram_q;
  logic [7:0]       cur_byte;
  logic [RAMAW-1:0] rd_addr;
  logic             in_byte;
  logic             last;
  logic             was_hi;
  logic             ram_re;
  logic             ram_we;
  logic             stop_hit;

  logic             dma_req;
  logic [7:0]       lp_data;
  logic             lp_stb;
  logic             lp_incbar;
  logic             lp_done;
  logic             busy;
  logic             err_undef;
  logic             err_go;
  logic             stopped;

  assign in_byte  = (state == S_LOW) || (state == S_HIGH);
  assign cur_byte = (state == S_HIGH) ? word[15:8] : word[7:0];
  assign rd_addr  = RAMAW'(cur_byte);
  assign stop_hit = bus.lpSTOP && (state != S_IDLE) && (state != S_FINISH);
  assign ram_re   = in_byte && (mode == M_PRINT) && !stop_hit && !rst;
  assign ram_we   = (state == S_LOW) && (mode == M_RAM) && !stop_hit && !rst;

  // Where to go once a byte is finished. In LOW/HIGH the counter has not yet
  // been decremented for the current byte, so "last" looks for 1 there.
  always_comb begin
    last      = in_byte ? (cnt == BCWID'(1)) : (cnt == '0);
    was_hi    = in_byte ? (state == S_HIGH) : hi;
    nxt_after = S_FETCH;
    if (mode == M_RAM)
      nxt_after = (cnt <= BCWID'(2)) ? S_FINISH : S_FETCH;
    else if (last)
      nxt_after = S_FINISH;
    else if (!was_hi)
      nxt_after = S_HIGH;
  end

  // Translation RAM: never reset, so a loaded table survives rst.
  always_ff @(posedge clk) begin
    if (ram_we) ram[widx] <= word[9:0];
    if (ram_re) ram_q <= ram[rd_addr];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      mode      <= M_PRINT;
      cnt       <= '0;
      word      <= '0;
      hi        <= 1'b0;
      widx      <= '0;
      dma_req   <= 1'b0;
      lp_data   <= '0;
      lp_stb    <= 1'b0;
      lp_incbar <= 1'b0;
      lp_done   <= 1'b0;
      busy      <= 1'b0;
      err_undef <= 1'b0;
      err_go    <= 1'b0;
      stopped   <= 1'b0;
    end else begin
      lp_stb    <= 1'b0;
      lp_incbar <= 1'b0;
      lp_done   <= 1'b0;
      if (bus.lpCMDGO && (state != S_IDLE)) err_go <= 1'b1;

      // Stop wins over anything else this cycle, including a DMA ack.
      if (stop_hit) begin
        dma_req <= 1'b0;
        stopped <= 1'b1;
        state   <= S_FINISH;
      end else begin
        case (state)
          S_IDLE: begin
            if (bus.lpCMDGO) begin
              cnt       <= bus.lpBCTR;
              mode      <= bus.lpMODE;
              widx      <= '0;
              err_undef <= 1'b0;
              err_go    <= 1'b0;
              stopped   <= 1'b0;
              busy      <= 1'b1;
              if (bus.lpBCTR == '0) begin
                state <= S_FINISH;
              end else begin
                state   <= S_FETCH;
                dma_req <= 1'b1;
              end
            end
          end
          S_FETCH: begin
            if (bus.dmaACK) begin
              word      <= bus.dmaDATA;
              lp_incbar <= 1'b1;
              dma_req   <= 1'b0;
              state     <= S_LOW;
            end
          end
          S_LOW, S_HIGH: begin
            hi <= (state == S_HIGH);
            if (mode == M_RAM) begin
              widx    <= widx + RAMAW'(1);
              cnt     <= (cnt > BCWID'(2)) ? cnt - BCWID'(2) : '0;
              state   <= nxt_after;
              dma_req <= (nxt_after == S_FETCH);
            end else begin
              cnt <= cnt - BCWID'(1);
              case (mode)
                M_PRINT: state <= S_XLATE;
                M_DAVFU: begin
                  lp_data <= cur_byte;
                  state   <= S_OUT;
                end
                default: begin
                  state   <= nxt_after;
                  dma_req <= (nxt_after == S_FETCH);
                end
              endcase
            end
          end
          S_XLATE: begin
            if (ram_q[9]) begin
              err_undef <= 1'b1;
              state     <= S_FINISH;
            end else if (ram_q[8]) begin
              state   <= nxt_after;
              dma_req <= (nxt_after == S_FETCH);
            end else begin
              lp_data <= ram_q[7:0];
              state   <= S_OUT;
            end
          end
          S_OUT: begin
            if (bus.lpRDY) begin
              lp_stb  <= 1'b1;
              state   <= nxt_after;
              dma_req <= (nxt_after == S_FETCH);
            end
          end
          S_FINISH: begin
            lp_done <= 1'b1;
            busy    <= 1'b0;
            state   <= S_IDLE;
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end

  assign bus.dmaREQ   = dma_req;
  assign bus.lpDATA   = lp_data;
  assign bus.lpSTB    = lp_stb;
  assign bus.lpINCBAR = lp_incbar;
  assign bus.lpDONE   = lp_done;
  assign bus.regCSRB  = {12'b0, stopped, err_go, err_undef, busy};
  assign dbg_state    = state;

endmodule

// File: doc/lp_xfer_ctrl.md
LP_XFER_CTRL -- requirements
Module: lp_xfer_ctrl

Interface
REQ-001 Parameter BCWID, default 12: byte-count width.
REQ-002 Parameter RAMAW, default 8: translation RAM address width; depth = 2**RAMAW entries of 10 bits.
REQ-003 Port clk  in  1  single clock; all state changes on rising edge.
REQ-004 Port rst  in  1  reset, synchronous, active-high.
REQ-005 Port lpMODE  in  2  mode: 0 PRINT, 1 TEST, 2 DAVFU, 3 RAM.
REQ-006 Port lpCMDGO  in  1  one-cycle go pulse.
REQ-007 Port lpSTOP  in  1  abort request.
REQ-008 Port lpBCTR  in  BCWID  byte count, sampled on accepted GO.
REQ-009 Port dmaREQ  out  1  DMA word request.
REQ-010 Port dmaACK  in  1  DMA word valid; dmaDATA qualified by it.
REQ-011 Port dmaDATA  in  16  DMA word: low byte first, then high byte.
REQ-012 Port lpDATA  out  8  printer character.
REQ-013 Port lpSTB  out  1  printer strobe.
REQ-014 Port lpRDY  in  1  printer ready.
REQ-015 Port lpINCBAR  out  1  one-cycle pulse: increment bus address register.
REQ-016 Port lpDONE  out  1  one-cycle pulse: transfer ended.
REQ-017 Port regCSRB  out  16  status: [0] busy, [1] undefined-char error, [2] GO-while-busy error, [3] stopped, [15:4] zero.

Function
REQ-018 States SHALL be IDLE, FETCH, LOW, XLATE, OUT, HIGH, FINISH.
REQ-019 IDLE + lpCMDGO SHALL load the byte counter from lpBCTR, clear regCSRB[3:1], set busy, and go to FETCH; if lpBCTR = 0, go to FINISH instead.
REQ-020 FETCH SHALL hold dmaREQ high until dmaACK; on dmaACK, latch dmaDATA, pulse lpINCBAR once, drop dmaREQ, and go to LOW.
REQ-021 LOW/HIGH SHALL select byte [7:0]/[15:8] of the latched word and decrement the byte counter by 1.
REQ-022 PRINT: each byte SHALL address the RAM (XLATE, 1-cycle read latency); entry[9] set -> set regCSRB[1] and go to FINISH; entry[8] set -> byte skipped; otherwise lpDATA = entry[7:0] and go to OUT.
REQ-023 DAVFU: bytes SHALL bypass the RAM and go straight to OUT untranslated.
REQ-024 TEST: bytes SHALL be consumed without RAM lookup or OUT; lpSTB stays low.
REQ-025 RAM mode: each DMA word SHALL write dmaDATA[9:0] to RAM address = word index (0 upward, wrapping at 2**RAMAW); the byte counter decrements by 2 per word, saturating at 0.
REQ-026 OUT SHALL assert lpSTB for exactly one cycle when lpRDY = 1, with lpDATA stable that cycle; otherwise wait in OUT.
REQ-027 After a byte: counter = 0 -> FINISH; after a low byte -> HIGH; after a high byte -> FETCH.
REQ-028 An odd byte count SHALL leave the final high byte unprocessed.
REQ-029 FINISH SHALL pulse lpDONE, clear busy, and return to IDLE in one cycle.
REQ-030 lpSTOP in any non-IDLE state SHALL drop dmaREQ and lpSTB, set regCSRB[3], and go to FINISH next cycle; lpSTOP has priority over dmaACK in the same cycle.
REQ-031 lpCMDGO while busy SHALL be ignored and SHALL set regCSRB[2].
REQ-032 RAM contents SHALL be read only in PRINT; RAM writes occur only in RAM mode.

Reset
REQ-033 rst SHALL force IDLE, byte counter 0, RAM write index 0, and dmaREQ, lpSTB, lpINCBAR, lpDONE = 0, lpDATA = 0, regCSRB = 0.
REQ-034 rst mid-transfer SHALL abort with no lpDONE pulse.
REQ-035 RAM contents SHALL NOT be cleared by rst.

Verification
REQ-036 RAM mode, BCTR=4, words 0x0041, 0x0142 -> RAM[0]=0x041, RAM[1]=0x142, 2 lpINCBAR pulses, 1 lpDONE.
REQ-037 PRINT, RAM[0x41]=0x058, BCTR=1, word 0x4241, lpRDY=1 -> one lpSTB with lpDATA=0x58, byte 0x42 not printed, lpDONE.
REQ-038 PRINT with entry[9] set for 0x41 -> no lpSTB, regCSRB=0x0002 after lpDONE.
REQ-039 DAVFU, BCTR=2, word 0x1234, lpRDY low 5 cycles -> lpSTB held off, then 0x34 then 0x12.
REQ-040 lpSTOP asserted with dmaACK in FETCH -> no lpINCBAR, regCSRB[3]=1, lpDONE next cycle.
REQ-041 lpCMDGO during a TEST transfer -> regCSRB[2]=1, transfer completes unchanged.
